// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester IDs.
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum bit {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_IFU) ? REQ_LSU : REQ_IFU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: valid[0] = IFU, valid[1] = LSU.
module rr_arb2
  import core_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic       gnt_valid,
  output req_id_t    gnt
);

  always_comb begin
    gnt_valid = |valid;
    gnt       = REQ_IFU;
    unique case (valid)
      2'b01:   gnt = REQ_IFU;
      2'b10:   gnt = REQ_LSU;
      2'b11:   gnt = other_req(last_grant);
      default: gnt = REQ_IFU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU fetch and LSU load/store,
// round-robin, one outstanding transaction at a time.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  req_id_t           owner_q;
  req_id_t           last_q;
  logic              lat_wen;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;

  logic    gnt_valid;
  req_id_t gnt;
  logic    accept;

  rr_arb2 u_rr (
    .valid      ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Readies are held low during reset so no handshake is signalled that
  // the reset would then silently drop.
  assign ifu_req_ready = !rst && (state_q == ARB_IDLE) && gnt_valid && (gnt == REQ_IFU);
  assign lsu_req_ready = !rst && (state_q == ARB_IDLE) && gnt_valid && (gnt == REQ_LSU);
  assign accept        = ifu_req_ready || lsu_req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (accept)         state_d = ARB_ISSUE;
      ARB_ISSUE: if (mem_req_ready)  state_d = ARB_WAIT;
      ARB_WAIT:  if (mem_resp_valid) state_d = ARB_IDLE;
      default:                       state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid  = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    if (!rst) begin
      unique case (state_q)
        ARB_ISSUE: begin
          mem_req_valid = 1'b1;
          mem_wen       = lat_wen;
          mem_addr      = lat_addr;
          mem_wdata     = lat_wdata;
          mem_wmask     = lat_wmask;
        end
        ARB_WAIT: begin
          if (owner_q == REQ_IFU) begin
            ifu_resp_valid = mem_resp_valid;
            ifu_rdata      = mem_rdata;
          end else begin
            lsu_resp_valid = mem_resp_valid;
            lsu_rdata      = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= REQ_IFU;
      last_q    <= REQ_IFU;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt;
        last_q  <= gnt;
        if (gnt == REQ_LSU) begin
          lat_wen   <= lsu_wen;
          lat_addr  <= lsu_addr;
          lat_wdata <= lsu_wdata;
          lat_wmask <= lsu_wmask;
        end else begin
          lat_wen   <= 1'b0;
          lat_addr  <= ifu_addr;
          lat_wdata <= '0;
          lat_wmask <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus sequences
// for stalled stores, reset mid-transaction and blocked fetch.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 8;
  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h8000_0100;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;

  int n_cmp  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst, iv, lv, mrdy, mresp;
    logic [31:0] mrdata;
    logic        e_irdy, e_lrdy, e_mv;
    logic [31:0] e_maddr;
    logic        e_iresp;
    logic [31:0] e_irdata;
    logic        e_lresp;
    logic [31:0] e_lrdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic r, iv, lv, mrdy, mresp, input logic [31:0] mrdata,
    input logic e_irdy, e_lrdy, e_mv, input logic [31:0] e_maddr,
    input logic e_iresp, input logic [31:0] e_irdata,
    input logic e_lresp, input logic [31:0] e_lrdata);
    vec_t v;
    v.rst = r; v.iv = iv; v.lv = lv; v.mrdy = mrdy; v.mresp = mresp; v.mrdata = mrdata;
    v.e_irdy = e_irdy; v.e_lrdy = e_lrdy; v.e_mv = e_mv; v.e_maddr = e_maddr;
    v.e_iresp = e_iresp; v.e_irdata = e_irdata; v.e_lresp = e_lresp; v.e_lrdata = e_lrdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
    ifu_addr = IA; lsu_addr = LA; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    int hs0;
    idle_inputs();
    rst = 1'b1;

    //      rst iv lv rdy rsp rdata         irdy lrdy mv maddr  iresp irdata        lresp lrdata
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,         0, 0, 1, IA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0413, 0, 0, 0, 32'h0, 1, 32'h0000_0413, 0, 32'h0));
    vq.push_back(mk(1, 1, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h0,         0, 0, 1, LA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h1111_1111, 0, 0, 0, 32'h0, 0, 32'h0,         1, 32'h1111_1111));
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h0,         0, 0, 1, IA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h2222_2222, 0, 0, 0, 32'h0, 1, 32'h2222_2222, 0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h0,         0, 0, 1, LA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h3333_3333, 0, 0, 0, 32'h0, 0, 32'h0,         1, 32'h3333_3333));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0BAD, 0, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0BAD, 0, 0, 1, IA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,         0, 0, 1, IA,    0, 32'h0,         0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0044, 0, 0, 0, 32'h0, 1, 32'h0000_0044, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; ifu_req_valid = vq[i].iv; lsu_req_valid = vq[i].lv;
      mem_req_ready = vq[i].mrdy; mem_resp_valid = vq[i].mresp; mem_rdata = vq[i].mrdata;
      #1;
      chk($sformatf("v%0d ifu_req_ready", i),  64'(ifu_req_ready),  64'(vq[i].e_irdy));
      chk($sformatf("v%0d lsu_req_ready", i),  64'(lsu_req_ready),  64'(vq[i].e_lrdy));
      chk($sformatf("v%0d mem_req_valid", i),  64'(mem_req_valid),  64'(vq[i].e_mv));
      chk($sformatf("v%0d mem_addr", i),       64'(mem_addr),       64'(vq[i].e_maddr));
      chk($sformatf("v%0d mem_wen", i),        64'(mem_wen),        64'(0));
      chk($sformatf("v%0d mem_wdata", i),      64'(mem_wdata),      64'(0));
      chk($sformatf("v%0d mem_wmask", i),      64'(mem_wmask),      64'(0));
      chk($sformatf("v%0d ifu_resp_valid", i), 64'(ifu_resp_valid), 64'(vq[i].e_iresp));
      chk($sformatf("v%0d ifu_rdata", i),      64'(ifu_rdata),      64'(vq[i].e_irdata));
      chk($sformatf("v%0d lsu_resp_valid", i), 64'(lsu_resp_valid), 64'(vq[i].e_lresp));
      chk($sformatf("v%0d lsu_rdata", i),      64'(lsu_rdata),      64'(vq[i].e_lrdata));
    end

    // Store held off by mem_req_ready=0 for three cycles.
    @(negedge clk);
    idle_inputs();
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    hs0 = hs_cnt;
    #1 chk("st accept", 64'(lsu_req_ready), 64'(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      lsu_addr = '0;
      #1;
      chk($sformatf("st stall%0d valid", c), 64'(mem_req_valid), 64'(1));
      chk($sformatf("st stall%0d wen", c),   64'(mem_wen),       64'(1));
      chk($sformatf("st stall%0d addr", c),  64'(mem_addr),      64'(32'h8000_1000));
      chk($sformatf("st stall%0d wdata", c), 64'(mem_wdata),     64'(32'hDEAD_BEEF));
      chk($sformatf("st stall%0d wmask", c), 64'(mem_wmask),     64'(8'h0F));
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1 chk("st issue valid", 64'(mem_req_valid), 64'(1));
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("st wait mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("st wait no ack", 64'(lsu_resp_valid), 64'(0));
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1 chk("st ack", 64'(lsu_resp_valid), 64'(1));
    chk("st ack ifu quiet", 64'(ifu_resp_valid), 64'(0));
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 chk("st one write issued", 64'(hs_cnt - hs0), 64'(1));

    // Reset while waiting for a fetch response.
    @(negedge clk);
    ifu_req_valid = 1'b1;
    #1 chk("rst accept", 64'(ifu_req_ready), 64'(1));
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hBAAD_F00D;
    #1;
    chk("rst mem_req_valid", 64'(mem_req_valid),  64'(0));
    chk("rst mem_addr",      64'(mem_addr),       64'(0));
    chk("rst ifu_resp",      64'(ifu_resp_valid), 64'(0));
    chk("rst ifu_rdata",     64'(ifu_rdata),      64'(0));
    chk("rst lsu_resp",      64'(lsu_resp_valid), 64'(0));
    chk("rst ifu_ready",     64'(ifu_req_ready),  64'(0));
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = '0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    #1 chk("rst new grant", 64'(ifu_req_ready), 64'(1));
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("rst new addr", 64'(mem_addr), 64'(32'h8000_0040));
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    #1 chk("rst new resp", 64'(ifu_rdata), 64'(32'h0000_0013));

    // Fetch blocked while an LSU load is outstanding.
    @(negedge clk);
    idle_inputs();
    lsu_req_valid = 1'b1;
    #1 chk("blk lsu accept", 64'(lsu_req_ready), 64'(1));
    @(negedge clk);
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; mem_req_ready = 1'b1;
    #1 chk("blk issue ifu_ready", 64'(ifu_req_ready), 64'(0));
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 chk("blk wait ifu_ready", 64'(ifu_req_ready), 64'(0));
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_5555;
    #1;
    chk("blk lsu resp", 64'(lsu_resp_valid), 64'(1));
    chk("blk resp ifu_ready", 64'(ifu_req_ready), 64'(0));
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 chk("blk ifu granted", 64'(ifu_req_ready), 64'(1));

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
